// File: rtl/mod_add_pkg.sv
// Shared types for the mod-16 adder feeder: default width, FSM states and the operand pair.
package mod_add_pkg;

  localparam int unsigned W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    RESULT = 2'd2
  } state_e;

  typedef struct packed {
    logic [W_DEF-1:0] a;
    logic [W_DEF-1:0] b;
  } pair_t;

endpackage

// File: rtl/mod_add_pair_fifo.sv
// Synchronous FIFO of operand pairs; peek shows the head as it will be after the coming edge.
module mod_add_pair_fifo
  import mod_add_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  pair_t                    push_data,
  output pair_t                    peek,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  pair_t          mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]  rd_nxt;
  logic [CW-1:0]  count_q, count_d;
  logic           full_q, full_d;
  logic           empty_q, empty_d;
  logic           do_push;
  logic           do_pop;

  // A full FIFO refuses a push even when it is popped in the same cycle.
  always_comb begin
    do_push  = push && !full_q;
    do_pop   = pop && !empty_q;
    rd_nxt   = rd_ptr_q + AW'(1);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_nxt;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_comb begin
    peek = mem_q[rd_ptr_q];
    if (do_pop) begin
      peek = (count_q > CW'(1)) ? mem_q[rd_nxt] : push_data;
    end else if (empty_q) begin
      peek = push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  assign full  = full_q;
  assign empty = empty_q;
  assign count = count_q;

endmodule

// File: rtl/mod_add_feeder.sv
// Feeds queued operand pairs to the registered mod-2^W adder and hands results downstream.
// Optional result checker enabled by defining MOD_ADD_FEED_CHECK_EN.
module mod_add_feeder
  import mod_add_pkg::*;
#(
  parameter int unsigned W     = W_DEF,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic [W-1:0] add_a,
  output logic [W-1:0] add_b,
  input  logic [W-1:0] add_out,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_data,
  output logic [W-1:0] res_a,
  output logic [W-1:0] res_b,
  output logic         err
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  state_e        state_q, state_d;
  logic [W-1:0]  add_a_q, add_a_d;
  logic [W-1:0]  add_b_q, add_b_d;
  logic          res_valid_q, res_valid_d;
  logic [W-1:0]  res_a_q, res_a_d;
  logic [W-1:0]  res_b_q, res_b_d;

  pair_t         push_pair;
  pair_t         peek;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          fifo_pop;
  logic          push_ok;

  assign push_pair.a = W_DEF'(in_a);
  assign push_pair.b = W_DEF'(in_b);
  assign push_ok     = in_valid && !fifo_full;

  mod_add_pair_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (in_valid),
    .pop       (fifo_pop),
    .push_data (push_pair),
    .peek      (peek),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Outputs are computed from the post-edge state and head so they register cleanly.
  always_comb begin
    state_d     = state_q;
    fifo_pop    = 1'b0;
    add_a_d     = '0;
    add_b_d     = '0;
    res_valid_d = 1'b0;
    res_a_d     = '0;
    res_b_d     = '0;
    unique case (state_q)
      IDLE:   if (!fifo_empty || push_ok) state_d = ISSUE;
      ISSUE:  state_d = RESULT;
      RESULT: begin
        if (res_ready) begin
          fifo_pop = 1'b1;
          state_d  = ((fifo_count > CW'(1)) || push_ok) ? ISSUE : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d != IDLE) begin
      add_a_d = W'(peek.a);
      add_b_d = W'(peek.b);
    end
    if (state_d == RESULT) begin
      res_valid_d = 1'b1;
      res_a_d     = W'(peek.a);
      res_b_d     = W'(peek.b);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      add_a_q     <= '0;
      add_b_q     <= '0;
      res_valid_q <= 1'b0;
      res_a_q     <= '0;
      res_b_q     <= '0;
    end else begin
      state_q     <= state_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      res_valid_q <= res_valid_d;
      res_a_q     <= res_a_d;
      res_b_q     <= res_b_d;
    end
  end

  assign in_ready  = !fifo_full;
  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign res_valid = res_valid_q;
  assign res_a     = res_a_q;
  assign res_b     = res_b_q;
  // The adder output is only meaningful while a result is presented.
  assign res_data  = res_valid_q ? add_out : '0;

`ifdef MOD_ADD_FEED_CHECK_EN
  logic [W-1:0] model_sum;
  logic         err_q, err_d;

  assign model_sum = add_a_q + add_b_q;

  always_comb begin
    err_d = err_q || ((state_q == RESULT) && (add_out != model_sum));
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mod_add_feeder.sv
// Scoreboard bench for mod_add_feeder with a behavioural registered adder in the loop.
module tb_mod_add_feeder;

  localparam int unsigned W     = 4;
  localparam int unsigned DEPTH = 4;

`ifdef MOD_ADD_FEED_CHECK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] sum;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [W-1:0] add_a;
  logic [W-1:0] add_b;
  logic [W-1:0] add_out;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_data;
  logic [W-1:0] res_a;
  logic [W-1:0] res_b;
  logic         err;

  exp_t sb_q[$];
  int   checks    = 0;
  int   errors    = 0;
  int   model_cnt = 0;
  bit   force_zero = 1'b0;

  always #5 clk = ~clk;

  mod_add_feeder #(
    .W     (W),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_out   (add_out),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_a     (res_a),
    .res_b     (res_b),
    .err       (err)
  );

  // Registered adder, optionally stuck at zero to provoke the checker.
  always_ff @(posedge clk) begin
    if (rst)             add_out <= '0;
    else if (force_zero) add_out <= '0;
    else                 add_out <= W'((int'(add_a) + int'(add_b)) % (1 << W));
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: accept/pop decided from the pre-edge model count, as the DUT sees them.
  always @(negedge clk) begin : monitor
    exp_t e;
    bit   acc;
    if (rst) begin
      sb_q.delete();
      model_cnt = 0;
    end else begin
      acc = in_valid && (model_cnt != DEPTH);
      check_val("in_ready", 32'(in_ready), 32'(model_cnt != DEPTH));
      if (res_valid && res_ready) begin
        if (sb_q.size() == 0) begin
          check_val("unexpected_result", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check_val("res_data", 32'(res_data), 32'(e.sum));
          check_val("res_a", 32'(res_a), 32'(e.a));
          check_val("res_b", 32'(res_b), 32'(e.b));
          model_cnt--;
        end
      end
      if (acc) begin
        e.a   = in_a;
        e.b   = in_b;
        e.sum = force_zero ? '0 : W'((int'(in_a) + int'(in_b)) % (1 << W));
        sb_q.push_back(e);
        model_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pair(input logic [W-1:0] a, input logic [W-1:0] b);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles);
    int n = 0;
    while ((res_valid || sb_q.size() != 0) && n < max_cycles) begin
      tick();
      n++;
    end
    check_val("drain_timeout", 32'(n < max_cycles), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    res_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;

    // Cold reset state
    check_val("rst_in_ready", 32'(in_ready), 32'd1);
    check_val("rst_res_valid", 32'(res_valid), 32'd0);
    check_val("rst_add_a", 32'(add_a), 32'd0);
    check_val("rst_add_b", 32'(add_b), 32'd0);
    check_val("rst_res_data", 32'(res_data), 32'd0);
    check_val("rst_res_a", 32'(res_a), 32'd0);
    check_val("rst_err", 32'(err), 32'd0);

    // Single pair 3+4: issue at cycle 1, result at cycle 2, idle at cycle 3
    push_pair(4'd3, 4'd4);
    check_val("t1_add_a", 32'(add_a), 32'd3);
    check_val("t1_add_b", 32'(add_b), 32'd4);
    check_val("t1_no_res_yet", 32'(res_valid), 32'd0);
    tick();
    check_val("t1_res_valid", 32'(res_valid), 32'd1);
    check_val("t1_res_data", 32'(res_data), 32'd7);
    tick();
    check_val("t1_idle_valid", 32'(res_valid), 32'd0);
    check_val("t1_idle_add_a", 32'(add_a), 32'd0);

    // Wrap: 9+9 = 2 mod 16
    push_pair(4'd9, 4'd9);
    tick();
    check_val("t2_res_data", 32'(res_data), 32'd2);
    check_val("t2_res_a", 32'(res_a), 32'd9);
    check_val("t2_res_b", 32'(res_b), 32'd9);
    wait_idle(20);

    // Backpressure: five back-to-back pushes, only four fit
    res_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_a = 4'(i + 1);
      in_b = 4'(2 * i + 3);
      if (i == 4) check_val("t3_full_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_val("t3_hold_valid", 32'(res_valid), 32'd1);
      check_val("t3_hold_data", 32'(res_data), 32'd4);
      check_val("t3_hold_a", 32'(res_a), 32'd1);
      tick();
    end
    res_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check_val("t3_drain_valid", 32'(res_valid), 32'd1);
      tick();
      check_val("t3_drain_gap", 32'(res_valid), 32'd0);
      tick();
    end
    check_val("t3_drain_empty", 32'(sb_q.size()), 32'd0);

    // Full FIFO: pop and push in the same cycle, push must be refused
    res_ready = 1'b0;
    push_pair(4'd10, 4'd1);
    push_pair(4'd11, 4'd2);
    push_pair(4'd12, 4'd3);
    push_pair(4'd13, 4'd4);
    tick();
    check_val("t4_full", 32'(in_ready), 32'd0);
    check_val("t4_in_result", 32'(res_valid), 32'd1);
    res_ready = 1'b1;
    in_valid  = 1'b1;
    in_a      = 4'd15;
    in_b      = 4'd15;
    tick();
    in_valid = 1'b0;
    check_val("t4_count3_ready", 32'(in_ready), 32'd1);
    wait_idle(40);

    // Reset while a result is pending and pairs are queued
    res_ready = 1'b0;
    push_pair(4'd1, 4'd2);
    push_pair(4'd3, 4'd5);
    push_pair(4'd7, 4'd6);
    tick();
    check_val("t5_pending", 32'(res_valid), 32'd1);
    do_reset();
    check_val("t5_res_valid", 32'(res_valid), 32'd0);
    check_val("t5_in_ready", 32'(in_ready), 32'd1);
    check_val("t5_add_a", 32'(add_a), 32'd0);
    check_val("t5_add_b", 32'(add_b), 32'd0);
    check_val("t5_res_data", 32'(res_data), 32'd0);
    res_ready = 1'b1;
    push_pair(4'd2, 4'd5);
    check_val("t5_add_a_after", 32'(add_a), 32'd2);
    tick();
    check_val("t5_res_after", 32'(res_data), 32'd7);
    wait_idle(20);

    // Corrupted adder output and sticky error flag
    check_val("t6_err_before", 32'(err), 32'd0);
    force_zero = 1'b1;
    push_pair(4'd1, 4'd1);
    wait_idle(20);
    force_zero = 1'b0;
    check_val("t6_err_set", 32'(err), 32'(ERR_EXP));
    push_pair(4'd6, 4'd7);
    wait_idle(20);
    check_val("t6_err_sticky", 32'(err), 32'(ERR_EXP));
    do_reset();
    check_val("t6_err_cleared", 32'(err), 32'd0);

    repeat (2) tick();
    check_val("final_sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mod_add_feeder.md
Name: mod_add_feeder

Overview:
- Upstream operand stage for the registered 4-bit mod-16 adder.
- Buffers incoming (a, b) operand pairs in a small FIFO and drives them onto the adder inputs one pair at a time.
- Holds each pair stable across the adder's 1-cycle latency, captures the adder output, and presents it downstream with a valid/ready handshake.

Parameters:
- W, 4, operand/result width (must match adder width).
- DEPTH, 4, FIFO entries; power of 2, >= 2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset; the same net also resets the adder.
- in_valid  in  1  upstream pair valid.
- in_ready  out  1  FIFO can accept a pair.
- in_a  in  W  operand a.
- in_b  in  W  operand b.
- add_a  out  W  to adder input a.
- add_b  out  W  to adder input b.
- add_out  in  W  from adder registered output.
- res_valid  out  1  result available.
- res_ready  in  1  downstream accepts result.
- res_data  out  W  sum mod 2^W.
- res_a  out  W  operand a echoed with the result.
- res_b  out  W  operand b echoed with the result.
- err  out  1  sticky mismatch flag (see Optional Feature).

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: FIFO empty (count=0, pointers 0), state IDLE, add_a=add_b=0, res_valid=0, res_data=res_a=res_b=0, err=0.
- Push: in_ready = (count != DEPTH). Push occurs when in_valid & in_ready. When full, a push is refused even if a pop happens the same cycle (no full pass-through). Input data is don't-care when in_valid=0.
- FSM states: IDLE, ISSUE, RESULT.
  - IDLE: add_a/add_b = 0. If FIFO is non-empty at the clock edge -> ISSUE. A pair pushed in cycle t is issued no earlier than t+1.
  - ISSUE (exactly 1 cycle): add_a/add_b = FIFO head. The adder samples at the end of this cycle. Next state: RESULT.
  - RESULT: add_a/add_b keep the head value, so add_out stays valid. res_valid=1, res_data=add_out, res_a/res_b = head. On res_ready: pop the head; if the FIFO still holds another entry -> ISSUE, else -> IDLE. Without res_ready: remain in RESULT with all outputs stable.
- Latency and throughput: first result at 2 cycles after the pair becomes head. Max throughput is 1 result per 2 cycles.
- Simultaneous push and pop in RESULT: count unchanged. The pushed entry queues behind the next head.
- Wrap-around: pointers are log2(DEPTH) bits and wrap naturally. Count is log2(DEPTH)+1 bits.
- Arithmetic: result is the adder's W-bit output. No carry is exposed.
- Reset mid-operation: any pending result and all queued pairs are discarded. res_valid drops in the cycle after rst is sampled.

Optional Feature:
- Macro: MOD_ADD_FEED_CHECK_EN.
- Defined: an internal model computes (head_a + head_b) truncated to W bits. In RESULT it is compared with add_out. Any mismatch sets err, which stays set until rst.
- Undefined: err is tied 0 and no comparator is generated.

Decomposition:
- Package mod_add_pkg holds: default W constant, FSM state enum (IDLE/ISSUE/RESULT), pair struct typedef {a, b}.
- One sub-module, mod_add_pair_fifo: synchronous FIFO of pair structs with push/pop/full/empty/count, parameterised by DEPTH.

Test Plan:
- Reset, then push a=3, b=4 at cycle 0 with res_ready=1 -> add_a=3/add_b=4 at cycle 1; res_valid=1, res_data=7 at cycle 2; IDLE at cycle 3.
- Push a=9, b=9 -> res_data=2 (wrap, 18 mod 16); res_a=9, res_b=9.
- Hold res_ready=0, push 5 pairs back-to-back (DEPTH=4) -> 4 accepted, in_ready=0 on the 5th; first result held stable; releasing res_ready drains the 4 results in push order, one every 2 cycles.
- Full FIFO with pop and push attempted in the same cycle -> push refused, count goes from 4 to 3.
- Assert rst while in RESULT with 3 pairs queued -> next cycle res_valid=0, in_ready=1, add_a=add_b=0; later pushes behave as after cold reset.
- With MOD_ADD_FEED_CHECK_EN defined, force add_out=0 for a=1, b=1 -> err=1, stays high until rst. Without the macro, err remains 0.
